// File: rtl/color_wheel_pwm.sv
// color_wheel_pwm: sweeps a hue counter around the RGB wheel
// (R->Y->G->C->B->M->R) and drives three PWM-dimmed LED channels.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   enable               - 1 = hue/prescaler advance, 0 = hold
//   direction            - 0 = hue up, 1 = hue down
//   discrete             - 1 = snap to whole segments, 0 = smooth fade
//   red, green, blue     - registered active-high PWM outputs
//   hue                  - current hue register
//   step                 - one-cycle pulse when a new hue is visible
module color_wheel_pwm #(
    parameter int PWM_BITS      = 8,
    parameter int STEP_INTERVAL = 46875,
    parameter int HUE_START     = 0,
    parameter int HUE_W         = $clog2(6 * (2 ** PWM_BITS))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             direction,
    input  logic             discrete,
    output logic             red,
    output logic             green,
    output logic             blue,
    output logic [HUE_W-1:0] hue,
    output logic             step
);

    localparam int SEG_W = HUE_W - PWM_BITS;
    localparam int PS_W  = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = MAX - 1'b1;
    localparam logic [HUE_W-1:0]    HUE_LAST = HUE_W'(6 * (2 ** PWM_BITS) - 1);
    localparam logic [SEG_W-1:0]    SEG_LAST = SEG_W'(5);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_INTERVAL - 1);

    logic [HUE_W-1:0]    r_hue;
    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty_r;
    logic [PWM_BITS-1:0] r_duty_g;
    logic [PWM_BITS-1:0] r_duty_b;
    logic                r_red;
    logic                r_green;
    logic                r_blue;
    logic                r_step;

    logic [SEG_W-1:0]    w_seg;
    logic [PWM_BITS-1:0] w_frac;
    logic [PWM_BITS-1:0] w_inv;
    logic [SEG_W-1:0]    w_seg_fwd;
    logic [SEG_W-1:0]    w_seg_rev;
    logic                w_tick;
    logic                w_period_end;
    logic [HUE_W-1:0]    w_hue_nxt;
    logic [PWM_BITS-1:0] w_duty_r;
    logic [PWM_BITS-1:0] w_duty_g;
    logic [PWM_BITS-1:0] w_duty_b;

    assign w_seg        = r_hue[HUE_W-1:PWM_BITS];
    assign w_frac       = r_hue[PWM_BITS-1:0];
    assign w_inv        = MAX - w_frac;
    assign w_seg_fwd    = (w_seg == SEG_LAST) ? '0 : w_seg + 1'b1;
    assign w_seg_rev    = (w_seg == '0) ? SEG_LAST : w_seg - 1'b1;
    assign w_tick       = enable && (r_presc == PS_LAST);
    assign w_period_end = (r_pwm_cnt == CNT_LAST);

    // Next hue, only consumed on a prescaler tick.
    always_comb begin
        w_hue_nxt = r_hue;
        unique case ({discrete, direction})
            2'b00: w_hue_nxt = (r_hue == HUE_LAST) ? '0 : r_hue + 1'b1;
            2'b01: w_hue_nxt = (r_hue == '0) ? HUE_LAST : r_hue - 1'b1;
            2'b10: w_hue_nxt = {w_seg_fwd, {PWM_BITS{1'b0}}};
            // Reverse snap: a partial segment first falls back to its own start.
            2'b11: w_hue_nxt = (w_frac != '0) ? {w_seg, {PWM_BITS{1'b0}}}
                                              : {w_seg_rev, {PWM_BITS{1'b0}}};
            default: w_hue_nxt = r_hue;
        endcase
    end

    // Hue to per-channel duty.
    always_comb begin
        w_duty_r = '0;
        w_duty_g = '0;
        w_duty_b = '0;
        unique case (w_seg)
            SEG_W'(0): begin w_duty_r = MAX;    w_duty_g = w_frac; end
            SEG_W'(1): begin w_duty_r = w_inv;  w_duty_g = MAX;    end
            SEG_W'(2): begin w_duty_g = MAX;    w_duty_b = w_frac; end
            SEG_W'(3): begin w_duty_g = w_inv;  w_duty_b = MAX;    end
            SEG_W'(4): begin w_duty_r = w_frac; w_duty_b = MAX;    end
            SEG_W'(5): begin w_duty_r = MAX;    w_duty_b = w_inv;  end
            default: begin
                w_duty_r = '0;
                w_duty_g = '0;
                w_duty_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hue     <= HUE_W'(HUE_START);
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_duty_r  <= '0;
            r_duty_g  <= '0;
            r_duty_b  <= '0;
            r_red     <= 1'b0;
            r_green   <= 1'b0;
            r_blue    <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            if (enable) begin
                r_presc <= (r_presc == PS_LAST) ? '0 : r_presc + 1'b1;
            end
            if (w_tick) begin
                r_hue <= w_hue_nxt;
            end
            r_step <= w_tick;

            r_pwm_cnt <= w_period_end ? '0 : r_pwm_cnt + 1'b1;
            // Duties only change at a period boundary so a period never
            // mixes two duty values; a same-edge hue step is seen next period.
            if (w_period_end) begin
                r_duty_r <= w_duty_r;
                r_duty_g <= w_duty_g;
                r_duty_b <= w_duty_b;
            end
            r_red   <= (r_pwm_cnt < r_duty_r);
            r_green <= (r_pwm_cnt < r_duty_g);
            r_blue  <= (r_pwm_cnt < r_duty_b);
        end
    end

    assign red   = r_red;
    assign green = r_green;
    assign blue  = r_blue;
    assign hue   = r_hue;
    assign step  = r_step;

endmodule

// File: tb/tb_color_wheel_pwm.sv
// tb_color_wheel_pwm: scoreboard bench for color_wheel_pwm
// (PWM_BITS=2, STEP_INTERVAL=4, HUE_START=0).
module tb_color_wheel_pwm;

    typedef struct {
        int hue;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       direction;
    logic       discrete;
    logic       red;
    logic       green;
    logic       blue;
    logic [4:0] hue;
    logic       step;

    exp_t sb[$];
    exp_t m_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   c_run  = 0;
    int   k_run  = 0;

    color_wheel_pwm #(
        .PWM_BITS     (2),
        .STEP_INTERVAL(4),
        .HUE_START    (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .direction(direction),
        .discrete (discrete),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .hue      (hue),
        .step     (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: every step pulse must match the oldest expectation,
    // both in hue value and in the cycle it appears.
    always @(negedge clk) begin
        if (rst_n && sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("step_missing_at_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (rst_n && step) begin
            if (sb.size() == 0) begin
                chk("unexpected_step_hue", int'(hue), -1);
            end else begin
                m_e = sb.pop_front();
                chk("step_hue", int'(hue), m_e.hue);
                chk("step_cycle", cyc, m_e.cyc);
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n     = 1'b0;
        enable    = 1'b0;
        direction = 1'b0;
        discrete  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hue", int'(hue), 0);
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_step", int'(step), 0);
        rst_n = 1'b1;
    endtask

    task automatic start_run;
        c_run  = cyc;
        k_run  = 0;
        enable = 1'b1;
    endtask

    task automatic expect_step(input int h);
        exp_t e;
        k_run++;
        e.hue = h;
        e.cyc = c_run + 4 * k_run;
        sb.push_back(e);
    endtask

    task automatic wait_run;
        repeat (4 * k_run) @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic pwm_win(input int n, output int r, output int g,
                           output int b);
        r = 0;
        g = 0;
        b = 0;
        repeat (n) begin
            @(negedge clk);
            r += int'(red);
            g += int'(green);
            b += int'(blue);
        end
    endtask

    // High counts over one 3-cycle PWM period after duties settle.
    task automatic check_rgb(input string tag, input int er, input int eg,
                             input int eb);
        int r, g, b;
        repeat (5) @(negedge clk);
        pwm_win(3, r, g, b);
        chk({tag, "_red"}, r, er);
        chk({tag, "_green"}, g, eg);
        chk({tag, "_blue"}, b, eb);
    endtask

    initial begin
        int r, g, b;
        rst_n     = 1'b0;
        enable    = 1'b0;
        direction = 1'b0;
        discrete  = 1'b0;

        // Reset then hold with enable low.
        do_reset();
        repeat (20) @(negedge clk);
        chk("hold_hue", int'(hue), 0);
        check_rgb("hold", 3, 0, 0);

        // Smooth forward sweep with pauses at interesting hues.
        start_run();
        expect_step(1);
        wait_run();
        check_rgb("h1", 3, 1, 0);
        start_run();
        for (int h = 2; h <= 4; h++) expect_step(h);
        wait_run();
        check_rgb("h4", 3, 3, 0);
        start_run();
        for (int h = 5; h <= 13; h++) expect_step(h);
        wait_run();
        check_rgb("h13", 0, 2, 3);
        start_run();
        for (int h = 14; h <= 23; h++) expect_step(h);
        expect_step(0);
        wait_run();
        check_rgb("h0", 3, 0, 0);

        // Reverse wrap straight out of reset.
        do_reset();
        direction = 1'b1;
        start_run();
        expect_step(23);
        wait_run();
        check_rgb("h23", 3, 0, 0);

        // Discrete mode.
        do_reset();
        discrete = 1'b1;
        start_run();
        expect_step(4);
        expect_step(8);
        expect_step(12);
        expect_step(16);
        expect_step(20);
        wait_run();
        check_rgb("h20", 3, 0, 3);
        direction = 1'b1;
        start_run();
        expect_step(16);
        wait_run();
        direction = 1'b0;
        start_run();
        expect_step(20);
        expect_step(0);
        expect_step(4);
        wait_run();
        discrete = 1'b0;
        start_run();
        expect_step(5);
        expect_step(6);
        wait_run();
        discrete  = 1'b1;
        direction = 1'b1;
        start_run();
        expect_step(4);
        expect_step(0);
        expect_step(20);
        wait_run();

        // Pause mid-interval at hue 21 (blue duty 2).
        discrete  = 1'b0;
        direction = 1'b0;
        start_run();
        expect_step(21);
        wait_run();
        check_rgb("h21", 3, 0, 2);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        pwm_win(9, r, g, b);
        chk("pause_blue_highs", b, 6);
        chk("pause_red_highs", r, 9);
        chk("pause_green_highs", g, 0);
        @(negedge clk);
        chk("pause_hue", int'(hue), 21);
        c_run = cyc;
        k_run = 0;
        begin
            exp_t e;
            e.hue = 22;
            e.cyc = c_run + 2;
            sb.push_back(e);
        end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;

        // Asynchronous reset between edges at hue 13.
        do_reset();
        start_run();
        for (int h = 1; h <= 13; h++) expect_step(h);
        wait_run();
        repeat (5) @(negedge clk);
        chk("pre_rst_blue", int'(blue), 1);
        chk("pre_rst_hue", int'(hue), 13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_hue", int'(hue), 0);
        chk("async_rgb", int'({red, green, blue}), 0);
        chk("async_step", int'(step), 0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
